// File: rtl/demux1to4_64bit_reg.sv
// Registered 1:4 demux. One cycle of latency from accept to out[sel]. in_ready drops only when out[sel] is FULL and not draining.
// The optional per-lane delivered-beat counters and the clear_stats/count ports are present only when DEMUX_STATS_EN is defined.
module demux1to4_64bit_reg #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out [3:0],
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready
`ifdef DEMUX_STATS_EN
    ,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] count [3:0]
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    lane_state_t      r_state [3:0];
    lane_state_t      w_state_nxt [3:0];
    logic [WIDTH-1:0] r_data [3:0];
    logic [3:0]       w_load;
    logic [3:0]       w_deliver;
    logic             w_accept;

    // Ready depends on the selected lane only, never on in_valid, so a
    // producer can safely wait for ready before raising valid.
    assign in_ready = ~reset & (~out_valid[sel] | out_ready[sel]);
    assign w_accept = in_valid & in_ready;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            out_valid[i] = (r_state[i] == FULL);
            out[i]       = r_data[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_load[i]      = 1'b0;
            w_deliver[i]   = 1'b0;
            w_state_nxt[i] = r_state[i];
            w_load[i]      = w_accept & (sel == 2'(i));
            w_deliver[i]   = out_valid[i] & out_ready[i];
            case (r_state[i])
                EMPTY:   if (w_load[i]) w_state_nxt[i] = FULL;
                FULL:    if (w_deliver[i] && !w_load[i]) w_state_nxt[i] = EMPTY;
                default: w_state_nxt[i] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= EMPTY;
                r_data[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= w_state_nxt[i];
                if (w_load[i]) r_data[i] <= in;
            end
        end
    end

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] r_count [3:0];

    // Clear takes priority over a delivery in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            for (int i = 0; i < 4; i++) r_count[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (w_deliver[i]) r_count[i] <= r_count[i] + CNT_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) count[i] = r_count[i];
    end
`endif

endmodule

// File: tb/tb_demux1to4_64bit_reg.sv
// Randomized and directed checks of demux1to4_64bit_reg against a lane-array reference model.
module tb_demux1to4_64bit_reg;
    localparam int WIDTH = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in;
    logic [1:0]       sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out [3:0];
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic             clear_stats;
`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] count [3:0];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: which lanes hold a word, their contents, and delivered-beat tallies.
    bit               m_full [4];
    logic [WIDTH-1:0] m_data [4];
    logic [CNT_W-1:0] m_cnt  [4];
    bit               m_last_accept;

    demux1to4_64bit_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef DEMUX_STATS_EN
        ,
        .clear_stats(clear_stats),
        .count      (count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Compare every output against the model at the negedge, then advance the model and the clock.
    task automatic step();
        bit exp_ready;
        bit acc;
        bit dlv;
        logic [3:0] exp_vld;
        @(negedge clk);
        exp_ready = !reset && (!m_full[sel] || out_ready[sel]);
        for (int i = 0; i < 4; i++) exp_vld[i] = m_full[i];
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("out_valid", 64'(out_valid), 64'(exp_vld));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("out[%0d]", i), out[i], m_data[i]);
`ifdef DEMUX_STATS_EN
            chk($sformatf("count[%0d]", i), 64'(count[i]), 64'(m_cnt[i]));
`endif
        end
        acc = in_valid && exp_ready;
        m_last_accept = acc;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_full[i] = 0;
                m_data[i] = '0;
                m_cnt[i]  = '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                dlv = m_full[i] && out_ready[i];
                if (clear_stats) m_cnt[i] = '0;
                else if (dlv) m_cnt[i] = m_cnt[i] + 1'b1;
                if (dlv) m_full[i] = 0;
            end
            if (acc) begin
                m_full[sel] = 1;
                m_data[sel] = in;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stream_lane1(input int n);
        out_ready = 4'b0010;
        sel = 2'd1;
        for (int k = 0; k < n; k++) begin
            in = 64'(k + 100);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        out_ready = 4'b0000;
    endtask

    initial begin
        bit hold;
        for (int i = 0; i < 4; i++) begin
            m_full[i] = 0;
            m_data[i] = 'x;
            m_cnt[i]  = 'x;
        end
        m_last_accept = 0;
        reset = 1'b1; in = '0; sel = '0; in_valid = 1'b0; out_ready = '0; clear_stats = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            m_data[i] = '0;
            m_cnt[i]  = '0;
        end
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_out[%0d]", i), out[i], 64'h0);

        in = 64'hDEAD_BEEF_0000_0001; sel = 2'd2; in_valid = 1'b1;
        step();
        chk("load_out2", out[2], 64'hDEAD_BEEF_0000_0001);
        chk("load_vld", 64'(out_valid), 64'h4);
        #1;
        chk("full_lane_ready", 64'(in_ready), 64'h0);
        sel = 2'd1;
        #1;
        chk("other_lane_ready", 64'(in_ready), 64'h1);
        in_valid = 1'b0;

        in = 64'h7; sel = 2'd3; in_valid = 1'b1;
        step();
        out_ready = 4'b1000; in = 64'h5;
        step();
        chk("reload_out3", out[3], 64'h5);
        chk("reload_vld3", 64'(out_valid[3]), 64'h1);
`ifdef DEMUX_STATS_EN
        chk("reload_cnt3", 64'(count[3]), 64'h1);
`endif
        out_ready = 4'b0000; in_valid = 1'b0;

        out_ready = 4'b0001; sel = 2'd0;
        for (int k = 1; k <= 8; k++) begin
            in = 64'(k); in_valid = 1'b1;
            #1;
            chk("stream_ready", 64'(in_ready), 64'h1);
            step();
            chk("stream_out0", out[0], 64'(k));
            chk("stream_vld0", 64'(out_valid[0]), 64'h1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", 64'(out_valid[0]), 64'h0);
`ifdef DEMUX_STATS_EN
        chk("stream_cnt0", 64'(count[0]), 64'h8);
`endif
        out_ready = 4'b0000;

        in_valid = 1'b1;
        sel = 2'd0; in = 64'hA0; step();
        sel = 2'd1; in = 64'hA1; step();
        in_valid = 1'b0;
        chk("fill_vld", 64'(out_valid), 64'hF);
        reset = 1'b1; in_valid = 1'b1; sel = 2'd2;
        step();
        reset = 1'b0; in_valid = 1'b0;
        chk("midrst_vld", 64'(out_valid), 64'h0);
        chk("midrst_out1", out[1], 64'h0);
`ifdef DEMUX_STATS_EN
        chk("midrst_cnt0", 64'(count[0]), 64'h0);
`endif

        stream_lane1((1 << CNT_W) - 1);
`ifdef DEMUX_STATS_EN
        chk("cnt1_max", 64'(count[1]), 64'hF);
`endif
        stream_lane1(1);
`ifdef DEMUX_STATS_EN
        chk("cnt1_wrap", 64'(count[1]), 64'h0);
`endif
        stream_lane1(2);
        sel = 2'd1; in = 64'hC1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 4'b0010; clear_stats = 1'b1;
        step();
        clear_stats = 1'b0; out_ready = 4'b0000;
`ifdef DEMUX_STATS_EN
        chk("clear_wins", 64'(count[1]), 64'h0);
`endif

        for (int c = 0; c < 3000; c++) begin
            hold = in_valid && !m_last_accept && !reset;
            reset = ($urandom_range(0, 99) == 0);
            clear_stats = ($urandom_range(0, 29) == 0);
            out_ready = 4'($urandom);
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                sel = 2'($urandom);
                in = {$urandom, $urandom};
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
